// File: rtl/div_sqrt_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_sqrt_issue_ctrl
//
// Initiator-side controller for the shared div/sqrt unit. Requests from the
// core are queued in a small FIFO. They are issued one at a time on the
// unit's start/Ready/Done pulse protocol. Each result comes back on a
// valid/ready response port together with its flags and tag.
//
// Optional feature macro: DIVSQRT_ISSUE_TIMEOUT_EN
//   If defined, a WAIT watchdog is added. After TIMEOUT_CYC cycles in WAIT
//   with no Done, the controller forces a response with result 32'h7FC00000
//   and flags 4'b1000, and pops the head entry.
//   If undefined, WAIT waits indefinitely and Resp_flags_DO[3] is always 0.
//
// Ports
//   Clk_CI, Rst_RI         clock, synchronous active-high reset
//   Req_*                  request channel (valid/ready, sqrt sel, a, b,
//                          rounding mode, precision, tag)
//   Resp_*                 response channel (valid/ready, result,
//                          flags {Timeout, Exp_OF, Exp_UF, Div_zero}, tag)
//   Busy_SO                FSM not idle, or FIFO not empty
//   Div_start_SO,
//   Sqrt_start_SO          one-cycle start pulses to the unit
//   Operand_a/b_DO,
//   RM_SO,
//   Precision_ctl_SO       head-of-FIFO operands, driven during ISSUE/WAIT
//   Unit_*                 unit Ready, Done, Result and flags
// ---------------------------------------------------------------------------
module div_sqrt_issue_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned C_DIV_RM    = 2,
  parameter int unsigned C_DIV_PC    = 5
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                Req_valid_SI,
  output logic                Req_ready_SO,
  input  logic                Req_sqrt_SI,
  input  logic [31:0]         Req_a_DI,
  input  logic [31:0]         Req_b_DI,
  input  logic [C_DIV_RM-1:0] Req_rm_SI,
  input  logic [C_DIV_PC-1:0] Req_pc_SI,
  input  logic [TAG_W-1:0]    Req_tag_DI,
  output logic                Resp_valid_SO,
  input  logic                Resp_ready_SI,
  output logic [31:0]         Resp_result_DO,
  output logic [3:0]          Resp_flags_DO,
  output logic [TAG_W-1:0]    Resp_tag_DO,
  output logic                Busy_SO,
  output logic                Div_start_SO,
  output logic                Sqrt_start_SO,
  output logic [31:0]         Operand_a_DO,
  output logic [31:0]         Operand_b_DO,
  output logic [C_DIV_RM-1:0] RM_SO,
  output logic [C_DIV_PC-1:0] Precision_ctl_SO,
  input  logic                Unit_ready_SI,
  input  logic                Unit_done_SI,
  input  logic [31:0]         Unit_result_DI,
  input  logic [2:0]          Unit_flags_DI
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                sqrt;
    logic [31:0]         a;
    logic [31:0]         b;
    logic [C_DIV_RM-1:0] rm;
    logic [C_DIV_PC-1:0] pc;
    logic [TAG_W-1:0]    tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  entry_t           fifo_q [DEPTH];
  entry_t           fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_ready_q, req_ready_d;
  logic [31:0]      resp_result_q, resp_result_d;
  logic [3:0]       resp_flags_q, resp_flags_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  entry_t head;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   timeout_hit;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  // Ready comes from a flop, so a push can never target a full FIFO.
  assign push       = Req_valid_SI & req_ready_q;
  assign pop        = (state_q == ST_WAIT) & (Unit_done_SI | timeout_hit);

`ifdef DIVSQRT_ISSUE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter restarts in ISSUE, so it reads 0 in the first WAIT cycle.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_ISSUE) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // A Done in the same cycle as the limit takes priority over the timeout.
  assign timeout_hit = (state_q == ST_WAIT) & ~Unit_done_SI &
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // FSM: state register
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty && Unit_ready_SI) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (pop) state_d = ST_RESP;
      ST_RESP:  if (Resp_ready_SI) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Div_start_SO     = 1'b0;
    Sqrt_start_SO    = 1'b0;
    Operand_a_DO     = '0;
    Operand_b_DO     = '0;
    RM_SO            = '0;
    Precision_ctl_SO = '0;
    Resp_valid_SO    = (state_q == ST_RESP);
    Busy_SO          = (state_q != ST_IDLE) | ~fifo_empty;
    if (state_q == ST_ISSUE) begin
      Div_start_SO  = ~head.sqrt;
      Sqrt_start_SO = head.sqrt;
    end
    if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      Operand_a_DO     = head.a;
      Operand_b_DO     = head.b;
      RM_SO            = head.rm;
      Precision_ctl_SO = head.pc;
    end
  end

  // Request FIFO and response register
  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_tag_d    = resp_tag_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{sqrt: Req_sqrt_SI, a: Req_a_DI, b: Req_b_DI,
                           rm: Req_rm_SI, pc: Req_pc_SI, tag: Req_tag_DI};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      resp_tag_d = head.tag;
      if (timeout_hit) begin
        resp_result_d = 32'h7FC0_0000;
        resp_flags_d  = 4'b1000;
      end else begin
        resp_result_d = Unit_result_DI;
        resp_flags_d  = {1'b0, Unit_flags_DI};
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    req_ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      req_ready_q   <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_tag_q    <= '0;
    end else begin
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      req_ready_q   <= req_ready_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_tag_q    <= resp_tag_d;
    end
  end

  assign Req_ready_SO   = req_ready_q;
  assign Resp_result_DO = resp_result_q;
  assign Resp_flags_DO  = resp_flags_q;
  assign Resp_tag_DO    = resp_tag_q;

endmodule
